// File: rtl/rv32_ifetch_align_pkg.sv
// Shared types for the RV32 fetch/align stage: FSM states, buffer layouts,
// the canonical NOP and the RVC parcel test.
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RV32_NOP = 32'h00000013;

    // Last fetched word; tag is the word address pc[31:2].
    typedef struct packed {
        logic [31:0] data;
        logic [29:0] tag;
        logic        v;
        logic        err;
    } word_buf_t;

    // Low half of a straddling 32-bit instruction; tag is the halfword address pc[31:1].
    typedef struct packed {
        logic [15:0] data;
        logic [30:0] tag;
        logic        v;
        logic        err;
    } spill_buf_t;

    // A 16-bit parcel is compressed unless its two low bits are both set.
    function automatic logic is_rvc(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/rv32_ifetch_align_if.sv
// Instruction-memory read bus: one outstanding request, completed by ack.
interface rv32_ifetch_align_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;

    // Fetch stage side
    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata, imem_err);
    // Memory side
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata, imem_err);
endinterface

// File: rtl/rv32_ifetch_align.sv
// Fetch/align stage: keeps the last fetched word plus one spill parcel and
// assembles 16/32-bit instructions at any halfword pc, combinationally on a
// buffer hit. Misses issue a single word-aligned read through a 3-state FSM.
module rv32_ifetch_align
    import rv32_pkg::*;
#(
    parameter bit          ENABLE_C  = 1'b1,
    parameter logic [31:0] NOP_INSTR = RV32_NOP
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                pc,
    input  logic                       flush,
    rv32_ifetch_align_if.master        imem,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr,
    output logic                       is_compressed,
    output logic                       fetch_fault,
    output logic                       pc_stall
);

    fetch_state_e r_state, w_state_nxt;
    word_buf_t    r_word;
    spill_buf_t   r_spill;
    logic [31:0]  r_addr;

    logic [29:0]  w_cur_wtag, w_nxt_wtag, w_need_wtag;
    logic         w_word_hit_cur, w_word_hit_nxt, w_spill_hit;
    logic [15:0]  w_lo, w_hi;
    logic         w_miss, w_spill_fill, w_issue, w_fill;

    assign w_cur_wtag     = pc[31:2];
    assign w_nxt_wtag     = pc[31:2] + 30'd1;   // wraps from the top word to word 0
    assign w_word_hit_cur = r_word.v && (r_word.tag == w_cur_wtag);
    assign w_word_hit_nxt = r_word.v && (r_word.tag == w_nxt_wtag);
    assign w_spill_hit    = r_spill.v && (r_spill.tag == pc[31:1]);
    assign w_lo           = r_word.data[15:0];
    assign w_hi           = r_word.data[31:16];

    // Instruction assembly from pc and the buffers; also decides which word a miss needs
    always_comb begin
        instr_valid   = 1'b0;
        instr         = NOP_INSTR;
        is_compressed = 1'b0;
        fetch_fault   = 1'b0;
        w_miss        = 1'b0;
        w_need_wtag   = w_cur_wtag;
        w_spill_fill  = 1'b0;
        if (pc[0] || (!ENABLE_C && pc[1])) begin
            // unreachable alignment: fault without touching the bus
            instr_valid = 1'b1;
            fetch_fault = 1'b1;
        end else if (!pc[1]) begin
            if (w_word_hit_cur) begin
                instr_valid = 1'b1;
                if (r_word.err) begin
                    fetch_fault = 1'b1;
                end else if (ENABLE_C && is_rvc(w_lo)) begin
                    instr         = {16'h0, w_lo};
                    is_compressed = 1'b1;
                end else begin
                    instr = r_word.data;
                end
            end else begin
                w_miss = 1'b1;
            end
        end else begin
            if (w_word_hit_cur && (r_word.err || is_rvc(w_hi))) begin
                instr_valid = 1'b1;
                if (r_word.err) begin
                    fetch_fault = 1'b1;
                end else begin
                    instr         = {16'h0, w_hi};
                    is_compressed = 1'b1;
                end
            end else if (w_spill_hit) begin
                // straddle: low parcel in spill, high parcel in the following word
                if (w_word_hit_nxt) begin
                    instr_valid = 1'b1;
                    if (r_spill.err || r_word.err)
                        fetch_fault = 1'b1;
                    else
                        instr = {w_lo, r_spill.data};
                end else begin
                    w_miss      = 1'b1;
                    w_need_wtag = w_nxt_wtag;
                end
            end else if (w_word_hit_cur) begin
                // park the upper parcel before the word buffer is overwritten
                w_spill_fill = 1'b1;
                w_miss       = 1'b1;
                w_need_wtag  = w_nxt_wtag;
            end else begin
                w_miss = 1'b1;
            end
        end
    end

    assign pc_stall = !(instr_valid && instr_ready);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state: a flush while waiting turns the pending read into a discard
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_miss && !flush) w_state_nxt = WAIT;
            WAIT:    if (imem.imem_ack)    w_state_nxt = IDLE;
                     else if (flush)       w_state_nxt = DISCARD;
            DISCARD: if (imem.imem_ack)    w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: request tracks the non-idle states, data is kept only from a live WAIT
    always_comb begin
        w_issue = (r_state == IDLE) && w_miss && !flush;
        w_fill  = (r_state == WAIT) && imem.imem_ack && !flush;
    end

    assign imem.imem_req  = (r_state != IDLE);
    assign imem.imem_addr = r_addr;

    // Request address: captured when a read is issued, held until the next issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_addr <= '0;
        else if (w_issue) r_addr <= {w_need_wtag, 2'b00};
    end

    // Word buffer: filled on a live ack, invalidated by flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_word <= '0;
        else if (flush)
            r_word.v <= 1'b0;
        else if (w_fill)
            r_word <= '{data: imem.imem_rdata, tag: r_addr[31:2], v: 1'b1, err: imem.imem_err};
    end

    // Spill buffer: holds the low half of a straddling instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_spill <= '0;
        else if (flush)
            r_spill.v <= 1'b0;
        else if (w_spill_fill)
            r_spill <= '{data: w_hi, tag: pc[31:1], v: 1'b1, err: r_word.err};
    end

endmodule
